// File: rtl/pte_fetch_arbiter_pkg.sv
// Shared definitions for the page-table-entry fetch arbiter: walk state
// encoding, PTE geometry and the beats-per-PTE derivation.
package pte_fetch_arbiter_pkg;

  localparam int PTE_W     = 32;
  localparam int PTE_BYTES = PTE_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Number of memory read beats needed to assemble one PTE.
  function automatic int beats_per_pte(input int beat_bytes);
    return PTE_BYTES / beat_bytes;
  endfunction

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pte_fetch_arbiter_rr.sv
// Round-robin arbiter: grants the requesting channel closest after 'last'
// (wrapping), so the most recently served channel has lowest priority.
module rr_arbiter
  import pte_fetch_arbiter_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [NUM_CH-1:0] grant
);

  // Distance of channel i from the first-priority slot (last+1).
  function automatic int rr_dist(input int i, input logic [CH_W-1:0] lst);
    return (i + NUM_CH - 1 - int'(lst)) % NUM_CH;
  endfunction

  // Pick the requester with the smallest distance; exactly one bit set.
  always_comb begin
    int best;
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    grant = '0;
    best  = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i] && (rr_dist(i, last) < best)) best = rr_dist(i, last);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = req[i] && (rr_dist(i, last) == best);
    end
  end

endmodule

// File: rtl/pte_fetch_arbiter.sv
// PTE fetch arbiter: arbitrates page-walk channels, reads one 32-bit PTE in
// NB little-endian beats and returns it to the granted channel. Misaligned
// addresses are answered immediately with an error and no memory access.
module pte_fetch_arbiter
  import pte_fetch_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        resp_valid,
  input  logic [NUM_CH-1:0]        resp_ready,
  output logic [PTE_W-1:0]         resp_data,
  output logic                     resp_err,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [8*BEAT_BYTES-1:0]  mem_rdata
);

  localparam int NB     = beats_per_pte(BEAT_BYTES);
  localparam int CH_W   = ch_idx_w(NUM_CH);
  localparam int BEAT_W = 8 * BEAT_BYTES;

  if (!(BEAT_BYTES == 1 || BEAT_BYTES == 2 || BEAT_BYTES == 4)) begin : g_bad_beat
    $fatal(1, "pte_fetch_arbiter: BEAT_BYTES must be 1, 2 or 4");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $fatal(1, "pte_fetch_arbiter: NUM_CH must be in 1..8");
  end

  state_t              state, state_nxt;
  logic [1:0]          beat_cnt;
  logic [ADDR_W-1:0]   base_addr;
  logic [CH_W-1:0]     cur_ch;
  logic [CH_W-1:0]     last_grant;
  logic [NUM_CH-1:0]   gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                gnt_fire;
  logic                handshake;
  logic                last_beat;
  logic                cap_en;
  logic [1:0]          cap_idx;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req   (req_valid),
    .last  (last_grant),
    .grant (gnt)
  );

  // Encode the one-hot grant and select the granted channel's address.
  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        gnt_idx  = CH_W'(i);
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign gnt_fire  = (state == IDLE) && !flush && (|req_valid);
  assign handshake = |(resp_valid & resp_ready);
  assign last_beat = (beat_cnt == 2'(NB - 1));
  // The beat issued last cycle lands now; DRAIN catches the final one.
  assign cap_en    = ((state == FETCH) && (beat_cnt != 2'd0)) || (state == DRAIN);
  assign cap_idx   = (state == DRAIN) ? 2'(NB - 1) : (beat_cnt - 2'd1);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic for the walk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_fire) state_nxt = (gnt_addr[1:0] == 2'b00) ? FETCH : RESP;
      FETCH:   if (flush) state_nxt = IDLE;
               else if (last_beat) state_nxt = DRAIN;
      DRAIN:   state_nxt = flush ? IDLE : RESP;
      RESP:    if (flush || handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the accept pulse is combinational in IDLE.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE:  if (gnt_fire && !rst) req_ready = gnt;
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = base_addr + (ADDR_W'(beat_cnt) * ADDR_W'(BEAT_BYTES));
      end
      RESP:  for (int i = 0; i < NUM_CH; i++) resp_valid[i] = (cur_ch == CH_W'(i));
      default: ;
    endcase
  end

  // Walk context, beat counter, PTE assembly and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= '0;
      base_addr  <= '0;
      cur_ch     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (cap_en) begin
        for (int k = 0; k < NB; k++) begin
          if (cap_idx == 2'(k)) resp_data[k*BEAT_W +: BEAT_W] <= mem_rdata;
        end
      end
      case (state)
        IDLE: if (gnt_fire) begin
          base_addr <= gnt_addr;
          cur_ch    <= gnt_idx;
          beat_cnt  <= '0;
          resp_data <= '0;
          resp_err  <= (gnt_addr[1:0] != 2'b00);
        end
        FETCH: beat_cnt <= last_beat ? 2'd0 : (beat_cnt + 2'd1);
        RESP: if (handshake) begin
          last_grant <= cur_ch;
          resp_data  <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
      // An aborted walk leaves nothing behind on the response outputs.
      if (flush && (state != IDLE)) begin
        beat_cnt  <= '0;
        resp_data <= '0;
        resp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pte_fetch_arbiter.sv
// Bench for pte_fetch_arbiter: a 4-channel byte-beat instance checked every
// cycle against a transaction-level model, plus a 2-channel word-beat
// instance for the response-stall case.
module tb_pte_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BB = 1;
  localparam int NB = 4 / BB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel, 1-byte-beat instance
  logic            rst, flush, resp_err, mem_req;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*AW-1:0] req_addr;
  logic [31:0]     resp_data;
  logic [AW-1:0]   mem_addr;
  logic [8*BB-1:0] mem_rdata;

  // 2-channel, 4-byte-beat instance
  logic            b_rst, b_flush, b_resp_err, b_mem_req;
  logic [1:0]      b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [2*AW-1:0] b_req_addr;
  logic [31:0]     b_resp_data;
  logic [AW-1:0]   b_mem_addr;
  logic [31:0]     b_mem_rdata;

  pte_fetch_arbiter #(.NUM_CH(N), .ADDR_W(AW), .BEAT_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  pte_fetch_arbiter #(.NUM_CH(2), .ADDR_W(AW), .BEAT_BYTES(4)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_addr(b_req_addr),
    .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_err(b_resp_err), .flush(b_flush),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata)
  );

  // Byte memory indexed by the low address byte; data one cycle after request.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    mem_rdata   <= mem[mem_addr[7:0]];
    b_mem_rdata <= {mem[8'(b_mem_addr[7:0] + 8'd3)], mem[8'(b_mem_addr[7:0] + 8'd2)],
                    mem[8'(b_mem_addr[7:0] + 8'd1)], mem[b_mem_addr[7:0]]};
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_busy;
  int            m_t;      // cycles since the accept cycle
  int            m_ch;
  int            m_last;
  bit            m_err;
  logic [AW-1:0] m_base;
  logic [31:0]   m_word;
  logic [N-1:0]  obs_ready;

  function automatic int rr_pick(input int last, input logic [N-1:0] rv);
    for (int d = 1; d <= N; d++) begin
      if (rv[(last + d) % N]) return (last + d) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pte_at(input logic [AW-1:0] a);
    logic [31:0]   w;
    logic [AW-1:0] ak;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      ak = a + AW'(k);
      w[k*8 +: 8] = mem[ak[7:0]];
    end
    return w;
  endfunction

  // Check the current cycle at the falling edge, advance the model across
  // the rising edge, and return #1 after it so the caller can drive inputs.
  task automatic tick();
    int g;
    int rs;
    @(negedge clk);
    obs_ready = req_ready;
    if (rst) begin
      check("rst_req_ready", 64'(req_ready), 64'(0));
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (!m_busy) begin
      g = flush ? -1 : rr_pick(m_last, req_valid);
      check("idle_mem_req",    64'(mem_req),    64'(0));
      check("idle_mem_addr",   64'(mem_addr),   64'(0));
      check("idle_resp_valid", 64'(resp_valid), 64'(0));
      check("idle_resp_data",  64'(resp_data),  64'(0));
      check("idle_resp_err",   64'(resp_err),   64'(0));
      check("grant",           64'(req_ready),  (g < 0) ? 64'(0) : 64'(1) << g);
      if (g >= 0) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_ch   = g;
        m_base = req_addr[g*AW +: AW];
        m_err  = (m_base[1:0] != 2'b00);
        m_word = m_err ? 32'h0 : pte_at(m_base);
      end
    end else begin
      m_t++;
      rs = m_err ? 1 : NB + 2;
      check("busy_req_ready", 64'(req_ready), 64'(0));
      if (!m_err && m_t <= NB) begin
        check("fetch_mem_req",  64'(mem_req),  64'(1));
        check("fetch_mem_addr", 64'(mem_addr), 64'(m_base + AW'((m_t - 1) * BB)));
      end else begin
        check("nofetch_mem_req",  64'(mem_req),  64'(0));
        check("nofetch_mem_addr", 64'(mem_addr), 64'(0));
      end
      if (m_t >= rs) begin
        check("resp_valid", 64'(resp_valid), 64'(1) << m_ch);
        check("resp_data",  64'(resp_data),  64'(m_word));
        check("resp_err",   64'(resp_err),   64'(m_err));
        if (resp_ready[m_ch]) m_last = m_ch;
        if (flush || resp_ready[m_ch]) m_busy = 1'b0;
      end else begin
        check("early_resp_valid", 64'(resp_valid), 64'(0));
        if (flush) m_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_addr   = '0;
    resp_ready = '0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid  = '0;
    flush      = 1'b0;
    resp_ready = '1;
    for (int i = 0; i < 20 && m_busy; i++) tick();
    resp_ready = '0;
  endtask

  // dut_b helpers
  int b_mreq_cnt;
  task automatic b_sample();
    @(negedge clk);
    if (b_mem_req) b_mreq_cnt++;
  endtask
  task automatic b_next();
    @(posedge clk);
    #1;
  endtask

  bit            pend  [N];
  logic [AW-1:0] paddr [N];
  int            order [5];
  int            n_g;
  bit            got_resp;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    clear_inputs();
    rst          = 1'b1;
    b_rst        = 1'b1;
    b_flush      = 1'b0;
    b_req_valid  = '0;
    b_req_addr   = '0;
    b_resp_ready = '0;
    m_busy       = 1'b0;
    m_last       = N - 1;
    @(posedge clk);
    #1;
    do_reset();

    // Single aligned walk: bytes EF BE AD DE at 0x100.
    mem[0] = 8'hEF; mem[1] = 8'hBE; mem[2] = 8'hAD; mem[3] = 8'hDE;
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 32'h100;
    tick();
    req_valid = '0;
    req_addr  = '0;
    for (int k = 0; k < 4; k++) begin
      check("d038_mem_addr", 64'(mem_addr), 64'(32'h100 + k));
      tick();
    end
    check("d038_not_yet_valid", 64'(resp_valid), 64'(0));
    tick();
    check("d038_resp_valid", 64'(resp_valid), 64'(4'b0001));
    check("d038_resp_data",  64'(resp_data),  64'(32'hDEADBEEF));
    check("d038_resp_err",   64'(resp_err),   64'(0));
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;

    // All four channels requesting continuously: order 0,1,2,3,0.
    do_reset();
    req_valid = '1;
    for (int c = 0; c < N; c++) req_addr[c*AW +: AW] = AW'(32'h200 + c * 4);
    resp_ready = '1;
    n_g = 0;
    for (int i = 0; i < 5; i++) order[i] = -1;
    for (int cyc = 0; cyc < 60 && n_g < 5; cyc++) begin
      tick();
      if (obs_ready != '0) begin
        for (int c = 0; c < N; c++) if (obs_ready[c]) order[n_g] = c;
        n_g++;
      end
    end
    check("d039_grant_count", 64'(n_g), 64'(5));
    check("d039_order0", 64'(order[0]), 64'(0));
    check("d039_order1", 64'(order[1]), 64'(1));
    check("d039_order2", 64'(order[2]), 64'(2));
    check("d039_order3", 64'(order[3]), 64'(3));
    check("d039_order4", 64'(order[4]), 64'(0));
    drain();

    // Misaligned request answered at T+1 with an error and no memory access.
    do_reset();
    req_valid = 4'b0010;
    req_addr[AW +: AW] = 32'h102;
    tick();
    req_valid = '0;
    check("d040_resp_valid", 64'(resp_valid), 64'(4'b0010));
    check("d040_resp_err",   64'(resp_err),   64'(1));
    check("d040_resp_data",  64'(resp_data),  64'(0));
    check("d040_mem_req",    64'(mem_req),    64'(0));
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;

    // Flush in the second FETCH cycle, then a normal walk.
    do_reset();
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 32'h40;
    tick();
    req_valid = '0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("d041_mem_req_dropped", 64'(mem_req),    64'(0));
    check("d041_no_resp",         64'(resp_valid), 64'(0));
    repeat (8) tick();
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 32'h80;
    tick();
    req_valid  = '0;
    resp_ready = 4'b0001;
    got_resp   = 1'b0;
    for (int i = 0; i < 20 && m_busy; i++) begin
      if (resp_valid == 4'b0001 && resp_data == pte_at(32'h80)) got_resp = 1'b1;
      tick();
    end
    check("d041_second_walk", 64'(got_resp), 64'(1));
    resp_ready = '0;

    // Reset during DRAIN, then channel 0 wins a tie with channel 1.
    do_reset();
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 32'h10;
    tick();
    req_valid = '0;
    repeat (NB) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("d043_mem_req",    64'(mem_req),    64'(0));
    check("d043_mem_addr",   64'(mem_addr),   64'(0));
    check("d043_resp_valid", 64'(resp_valid), 64'(0));
    check("d043_resp_data",  64'(resp_data),  64'(0));
    check("d043_resp_err",   64'(resp_err),   64'(0));
    check("d043_req_ready",  64'(req_ready),  64'(0));
    req_valid = 4'b0011;
    req_addr[0 +: AW]  = 32'h20;
    req_addr[AW +: AW] = 32'h24;
    tick();
    check("d043_first_grant", 64'(obs_ready), 64'(4'b0001));
    drain();

    // Randomized traffic: holds, withdrawals, address churn, flushes, stalls.
    do_reset();
    for (int c = 0; c < N; c++) pend[c] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[c]  = 1'b1;
            paddr[c] = AW'($urandom);
            if ($urandom_range(0, 7) != 0) paddr[c][1:0] = 2'b00;
          end else begin
            paddr[c] = AW'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[c] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          paddr[c] = {paddr[c][AW-1:2] + 30'($urandom_range(1, 5)), paddr[c][1:0]};
        end
        req_valid[c]          = pend[c];
        req_addr[c*AW +: AW] = paddr[c];
      end
      flush      = ($urandom_range(0, 39) == 0);
      resp_ready = flush ? '0 : N'($urandom);
      tick();
      if (m_busy && m_t == 0) pend[m_ch] = 1'b0;
    end
    clear_inputs();
    drain();

    // Word-beat instance: response stalled for five cycles.
    b_rst = 1'b0;
    mem[8'h80] = 8'h11; mem[8'h81] = 8'h22; mem[8'h82] = 8'h33; mem[8'h83] = 8'h44;
    b_req_valid = 2'b01;
    b_req_addr[0 +: AW] = 32'h80;
    b_mreq_cnt = 0;
    b_sample();
    check("d042_grant", 64'(b_req_ready), 64'(2'b01));
    b_next();
    b_req_valid = '0;
    b_sample();
    check("d042_mem_req",  64'(b_mem_req),  64'(1));
    check("d042_mem_addr", 64'(b_mem_addr), 64'(32'h80));
    b_next();
    b_sample();
    check("d042_not_yet_valid", 64'(b_resp_valid), 64'(0));
    b_next();
    for (int i = 0; i < 5; i++) begin
      b_sample();
      check("d042_stall_valid", 64'(b_resp_valid), 64'(2'b01));
      check("d042_stall_data",  64'(b_resp_data),  64'(32'h44332211));
      check("d042_stall_err",   64'(b_resp_err),   64'(0));
      b_next();
    end
    b_resp_ready = 2'b01;
    b_sample();
    check("d042_hs_valid", 64'(b_resp_valid), 64'(2'b01));
    b_next();
    b_resp_ready = '0;
    b_sample();
    check("d042_released",  64'(b_resp_valid), 64'(0));
    check("d042_mem_req_n", 64'(b_mreq_cnt),   64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pte_fetch_arbiter.md
PTE_FETCH_ARBITER -- requirements
Module: pte_fetch_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of page-walk requester channels, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: physical address width.
REQ-003 SHALL have parameter BEAT_BYTES, default 1: bytes per memory read beat; legal values 1, 2, 4.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, NUM_CH: per-channel fetch request.
REQ-007 SHALL have port req_addr, input, NUM_CH*ADDR_W: packed per-channel PTE address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_ready, output, NUM_CH: one-hot accept pulse.
REQ-009 SHALL have port resp_valid, output, NUM_CH: one-hot response valid.
REQ-010 SHALL have port resp_ready, input, NUM_CH: per-channel response consume.
REQ-011 SHALL have port resp_data, output, 32: assembled PTE, shared by all channels.
REQ-012 SHALL have port resp_err, output, 1: misaligned-address error, qualified by resp_valid.
REQ-013 SHALL have port flush, input, 1: abort the walk in progress.
REQ-014 SHALL have port mem_req, output, 1: memory read strobe.
REQ-015 SHALL have port mem_addr, output, ADDR_W: memory read byte address.
REQ-016 SHALL have port mem_rdata, input, 8*BEAT_BYTES: read data, valid exactly one cycle after mem_req.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, RESP.
REQ-018 IDLE: grant = round-robin over req_valid, searching from (last_grant+1) mod NUM_CH; assert req_ready[grant] for that cycle only; latch address and channel.
REQ-019 IDLE transition: go to FETCH if latched addr[1:0]==0, else go to RESP with resp_err=1 and resp_data=0, issuing no memory access.
REQ-020 FETCH: assert mem_req every cycle; mem_addr = base + k*BEAT_BYTES for k = 0..NB-1, where NB = 4/BEAT_BYTES; go to DRAIN after beat NB-1.
REQ-021 Data capture: mem_rdata of beat k SHALL be written to resp_data bytes [k*BEAT_BYTES +: BEAT_BYTES] (little-endian) one cycle after its issue; DRAIN captures the final beat, then goes to RESP.
REQ-022 Latency: request accepted in cycle T -> resp_valid asserted in cycle T+NB+2 (T+6 for BEAT_BYTES=1, T+3 for BEAT_BYTES=4).
REQ-023 RESP: hold resp_valid[ch], resp_data and resp_err stable until resp_ready[ch]; on the cycle resp_valid & resp_ready is seen, update last_grant=ch and return to IDLE.
REQ-024 Back-to-back: no new grant in the cycle that consumes a response; the next grant occurs one cycle later, in IDLE.
REQ-025 No request pending in IDLE: hold all outputs at reset values.
REQ-026 flush in FETCH or DRAIN: go to IDLE next cycle, drop mem_req, emit no resp_valid, leave last_grant unchanged.
REQ-027 flush in RESP: clear resp_valid and go to IDLE.
REQ-028 flush in IDLE: block any grant that cycle.
REQ-029 Address arithmetic SHALL be ADDR_W bits and wrap modulo 2^ADDR_W.
REQ-030 A request withdrawn before it is granted SHALL be ignored.
REQ-031 req_addr SHALL be sampled only on its grant cycle.

Reset
REQ-032 rst SHALL force state=IDLE; req_ready=0, resp_valid=0, resp_data=0, resp_err=0, mem_req=0, mem_addr=0, beat counter=0.
REQ-033 rst SHALL set last_grant=NUM_CH-1 so channel 0 has first priority.
REQ-034 rst mid-walk SHALL abort without a response; rst overrides flush and all requests.

Structure
REQ-035 A shared package SHALL hold the state encoding, the PTE width constant (32), and the derivation NB=4/BEAT_BYTES.
REQ-036 The round-robin grant logic SHALL be a sub-module rr_arbiter, parametrised by NUM_CH, with inputs req, last and output one-hot grant.
REQ-037 The design SHALL be elaboration-time-checked: any BEAT_BYTES outside {1,2,4} is a fatal error.

Verification
REQ-038 BEAT_BYTES=1: ch0 req addr 0x100, memory bytes 0x100..0x103 = EF BE AD DE -> mem_addr 0x100..0x103 on consecutive cycles; resp_valid[0] at T+6; resp_data=0xDEADBEEF; resp_err=0.
REQ-039 NUM_CH=4: ch0..ch3 all request continuously with resp_ready=1 -> grant order 0,1,2,3,0; no channel granted twice in a row.
REQ-040 Misaligned request ch1 addr 0x102 -> mem_req never asserted; resp_valid[1] with resp_err=1, resp_data=0 at T+1.
REQ-041 flush asserted in the second FETCH cycle -> mem_req low the next cycle; no resp_valid; state IDLE; a subsequent request completes normally.
REQ-042 BEAT_BYTES=4 with resp_ready held low 5 cycles -> a single mem_req; resp_valid and resp_data stable for all 5 cycles; released on the handshake.
REQ-043 rst pulsed during DRAIN -> all outputs 0 next cycle; the first grant after reset goes to ch0 when ch0 and ch1 both request.
